// File: rtl/avl_mm_initiator_pkg.sv
// Shared types for the Avalon-MM initiator: FSM states, latched command and held response.
package avl_mm_initiator_pkg;

  localparam int AVL_ADDRSIZE = 14;
  localparam int AVL_DATASIZE = 32;
  localparam int AVL_BESIZE   = AVL_DATASIZE / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [AVL_ADDRSIZE-1:0] address;
    logic [AVL_BESIZE-1:0]   byteenable;
    logic [AVL_DATASIZE-1:0] writedata;
  } cmd_t;

  typedef struct packed {
    logic                    write;
    logic [AVL_DATASIZE-1:0] readdata;
    logic                    error;
  } rsp_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/avl_mm_initiator.sv
// Single-transaction Avalon-MM initiator: command in, one read/write on the bus, response out.
// Struct field widths come from the package, so ADDRSIZE/DATASIZE track its constants.
module avl_mm_initiator
  import avl_mm_initiator_pkg::*;
#(
  parameter int ADDRSIZE = AVL_ADDRSIZE,
  parameter int DATASIZE = AVL_DATASIZE,
  parameter int TIMEOUT  = 256
) (
  input  logic                  avl_clk_i,
  input  logic                  avl_reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDRSIZE-1:0]   cmd_address_i,
  input  logic [DATASIZE/8-1:0] cmd_byteenable_i,
  input  logic [DATASIZE-1:0]   cmd_writedata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [DATASIZE-1:0]   rsp_readdata_o,
  output logic                  rsp_error_o,
  output logic [ADDRSIZE-1:0]   avl_address_o,
  output logic [DATASIZE/8-1:0] avl_byteenable_o,
  output logic                  avl_write_o,
  output logic                  avl_read_o,
  output logic [DATASIZE-1:0]   avl_writedata_o,
  input  logic [DATASIZE-1:0]   avl_readdata_i,
  input  logic                  avl_waitrequest_i,
  input  logic                  avl_readdatavalid_i,
  output logic [15:0]           timeout_count_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  cmd_t        r_cmd, w_cmd_next;
  rsp_t        r_rsp, w_rsp_next;
  logic        r_cmd_ready, w_cmd_ready_next;
  logic        r_rsp_valid, w_rsp_valid_next;
  logic        r_avl_read, w_avl_read_next;
  logic        r_avl_write, w_avl_write_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [15:0] r_timeout_count, w_timeout_count_next;
  logic        w_expired;

  assign w_expired = (r_cnt == TO_LAST);

  always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
    if (avl_reset_i) begin
      r_state         <= IDLE;
      r_cmd           <= '0;
      r_rsp           <= '0;
      r_cmd_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_avl_read      <= 1'b0;
      r_avl_write     <= 1'b0;
      r_cnt           <= '0;
      r_timeout_count <= '0;
    end else begin
      r_state         <= w_state_next;
      r_cmd           <= w_cmd_next;
      r_rsp           <= w_rsp_next;
      r_cmd_ready     <= w_cmd_ready_next;
      r_rsp_valid     <= w_rsp_valid_next;
      r_avl_read      <= w_avl_read_next;
      r_avl_write     <= w_avl_write_next;
      r_cnt           <= w_cnt_next;
      r_timeout_count <= w_timeout_count_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_cmd_next           = r_cmd;
    w_rsp_next           = r_rsp;
    w_cmd_ready_next     = r_cmd_ready;
    w_rsp_valid_next     = r_rsp_valid;
    w_avl_read_next      = r_avl_read;
    w_avl_write_next     = r_avl_write;
    w_cnt_next           = r_cnt;
    w_timeout_count_next = r_timeout_count;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid_i && r_cmd_ready) begin
          w_cmd_next       = '{write: cmd_write_i, address: cmd_address_i,
                               byteenable: cmd_byteenable_i, writedata: cmd_writedata_i};
          w_avl_read_next  = !cmd_write_i;
          w_avl_write_next = cmd_write_i;
          w_cmd_ready_next = 1'b0;
          w_cnt_next       = '0;
          w_state_next     = REQ;
        end
      end
      REQ: begin
        // A bus accept beats a timeout landing on the same cycle.
        if (!avl_waitrequest_i) begin
          w_avl_read_next  = 1'b0;
          w_avl_write_next = 1'b0;
          if (r_cmd.write) begin
            w_rsp_next       = '{write: 1'b1, readdata: '0, error: 1'b0};
            w_rsp_valid_next = 1'b1;
            w_state_next     = RESP;
          end else if (avl_readdatavalid_i) begin
            w_rsp_next       = '{write: 1'b0, readdata: avl_readdata_i, error: 1'b0};
            w_rsp_valid_next = 1'b1;
            w_state_next     = RESP;
          end else begin
            w_cnt_next   = '0;
            w_state_next = WAIT_DATA;
          end
        end else if (w_expired) begin
          w_avl_read_next      = 1'b0;
          w_avl_write_next     = 1'b0;
          w_rsp_next           = '{write: r_cmd.write, readdata: '0, error: 1'b1};
          w_rsp_valid_next     = 1'b1;
          w_timeout_count_next = sat_inc16(r_timeout_count);
          w_state_next         = RESP;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      WAIT_DATA: begin
        if (avl_readdatavalid_i) begin
          w_rsp_next       = '{write: 1'b0, readdata: avl_readdata_i, error: 1'b0};
          w_rsp_valid_next = 1'b1;
          w_state_next     = RESP;
        end else if (w_expired) begin
          w_rsp_next           = '{write: 1'b0, readdata: '0, error: 1'b1};
          w_rsp_valid_next     = 1'b1;
          w_timeout_count_next = sat_inc16(r_timeout_count);
          w_state_next         = RESP;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_next = 1'b0;
          w_cmd_ready_next = 1'b1;
          w_state_next     = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign cmd_ready_o      = r_cmd_ready;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_write_o      = r_rsp.write;
  assign rsp_readdata_o   = r_rsp.readdata;
  assign rsp_error_o      = r_rsp.error;
  assign avl_address_o    = r_cmd.address;
  assign avl_byteenable_o = r_cmd.byteenable;
  assign avl_writedata_o  = r_cmd.writedata;
  assign avl_read_o       = r_avl_read;
  assign avl_write_o      = r_avl_write;
  assign timeout_count_o  = r_timeout_count;

endmodule

// File: tb/tb_avl_mm_initiator.sv
// Directed bench for avl_mm_initiator with TIMEOUT = 8.
module tb_avl_mm_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [13:0] cmd_address = '0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;
  logic [13:0] avl_address;
  logic [3:0]  avl_be;
  logic        avl_write, avl_read;
  logic [31:0] avl_wdata, avl_rdata = '0;
  logic        avl_wr = 1'b0, avl_rdv = 1'b0;
  logic [15:0] to_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avl_mm_initiator #(.ADDRSIZE(14), .DATASIZE(32), .TIMEOUT(8)) dut (
    .avl_clk_i(clk), .avl_reset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_address_i(cmd_address), .cmd_byteenable_i(cmd_be), .cmd_writedata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_readdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .avl_address_o(avl_address), .avl_byteenable_o(avl_be), .avl_write_o(avl_write),
    .avl_read_o(avl_read), .avl_writedata_o(avl_wdata), .avl_readdata_i(avl_rdata),
    .avl_waitrequest_i(avl_wr), .avl_readdatavalid_i(avl_rdv), .timeout_count_o(to_count)
  );

  // Presents a command for one edge; caller starts at posedge+1 with the DUT in IDLE.
  task automatic issue_cmd(input logic w, input logic [13:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_be = be; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [51:0] got, exp;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {cmd_ready, rsp_valid, rsp_write, rsp_error, avl_read, avl_write, avl_address, avl_be, to_count, 14'd0};
    exp = {1'b1, 5'b0, 14'h0, 4'h0, 16'h0, 14'd0};
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", got, exp); end
    n_cmp++;
    if ({rsp_rdata, avl_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h expected 0/0", rsp_rdata, avl_wdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, avl_read, avl_write} !== 4'b1000) begin
      n_err++; $display("FAIL idle_rsp_ready: got %b expected 1000", {cmd_ready, rsp_valid, avl_read, avl_write});
    end
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  task automatic test_write();
    avl_wr = 1'b0;
    issue_cmd(1'b1, 14'h0004, 4'hF, 32'hA5A5_0001);
    @(negedge clk);
    n_cmp++;
    if ({avl_write, avl_read, avl_address, avl_be, avl_wdata, cmd_ready, rsp_valid} !==
        {1'b1, 1'b0, 14'h0004, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL write_req: wr=%b rd=%b addr=%h be=%h wd=%h expected 1 0 0004 f a5a50001",
                        avl_write, avl_read, avl_address, avl_be, avl_wdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({avl_write, rsp_valid, rsp_error, rsp_write, rsp_rdata} !== {1'b0, 1'b1, 1'b0, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL write_rsp: got %h expected %h",
                        {avl_write, rsp_valid, rsp_error, rsp_write, rsp_rdata}, {1'b0, 1'b1, 1'b0, 1'b1, 32'h0});
    end
    finish_rsp();
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL write_handshake: got %b expected 10", {cmd_ready, rsp_valid});
    end
    @(posedge clk); #1;
    $display("write: addr=0004 data=a5a50001 rsp_error=%b", rsp_error);
  endtask

  task automatic test_read_stall();
    avl_wr = 1'b1;
    issue_cmd(1'b0, 14'h0000, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({avl_read, avl_write, avl_address, avl_be} !== {1'b1, 1'b0, 14'h0, 4'hF}) begin
        n_err++; $display("FAIL stall_hold%0d: rd=%b addr=%h be=%h expected 1 0000 f", i, avl_read, avl_address, avl_be);
      end
      @(posedge clk); #1;
    end
    avl_wr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({avl_read, rsp_valid} !== 2'b00) begin
      n_err++; $display("FAIL wait_data: rd=%b rsp_valid=%b expected 0 0", avl_read, rsp_valid);
    end
    @(posedge clk); #1;
    avl_rdv = 1'b1; avl_rdata = 32'h0000_1234;
    @(posedge clk); #1;
    avl_rdv = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_error, rsp_write, rsp_rdata} !== {3'b100, 32'h1234}) begin
      n_err++; $display("FAIL read_stall_rsp: got %h expected %h", {rsp_valid, rsp_error, rsp_write, rsp_rdata}, {3'b100, 32'h1234});
    end
    finish_rsp();
    $display("read_stall: addr=0000 data=%h", rsp_rdata);
  endtask

  task automatic test_read_same_cycle();
    avl_wr = 1'b0;
    issue_cmd(1'b0, 14'h0ABC, 4'h3, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({avl_read, avl_address, avl_be} !== {1'b1, 14'h0ABC, 4'h3}) begin
      n_err++; $display("FAIL direct_req: rd=%b addr=%h be=%h expected 1 0abc 3", avl_read, avl_address, avl_be);
    end
    avl_rdv = 1'b1; avl_rdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    avl_rdv = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({avl_read, rsp_valid, rsp_error, rsp_write, rsp_rdata} !== {4'b0100, 32'hCAFE}) begin
      n_err++; $display("FAIL direct_rsp: got %h expected %h", {avl_read, rsp_valid, rsp_error, rsp_write, rsp_rdata}, {4'b0100, 32'hCAFE});
    end
    finish_rsp();
    $display("read_direct: addr=0abc data=%h", rsp_rdata);
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    avl_wr = 1'b1;
    issue_cmd(1'b0, 14'h0008, 4'hF, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!avl_read) break;
      hi++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (hi !== 8) begin n_err++; $display("FAIL timeout_strobe_cycles: got %0d expected 8", hi); end
    n_cmp++;
    if ({rsp_valid, rsp_error, rsp_write, rsp_rdata, to_count} !== {3'b110, 32'h0, 16'd1}) begin
      n_err++; $display("FAIL timeout_rsp: valid=%b err=%b wr=%b data=%h cnt=%0d expected 1 1 0 0 1",
                        rsp_valid, rsp_error, rsp_write, rsp_rdata, to_count);
    end
    avl_wr = 1'b0;
    finish_rsp();
    $display("timeout: strobe_cycles=%0d timeout_count=%0d", hi, to_count);
  endtask

  task automatic test_rsp_hold();
    avl_wr = 1'b0;
    issue_cmd(1'b0, 14'h0020, 4'hF, 32'h0);
    avl_rdv = 1'b1; avl_rdata = 32'h0000_0055;
    @(posedge clk); #1;
    avl_rdata = 32'h0000_FFFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 14'h0010; cmd_be = 4'hF; cmd_wdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_error, rsp_write, rsp_rdata, cmd_ready, avl_read, avl_write} !== {3'b100, 32'h55, 3'b000}) begin
        n_err++; $display("FAIL rsp_hold%0d: got %h expected %h", i,
                          {rsp_valid, rsp_error, rsp_write, rsp_rdata, cmd_ready, avl_read, avl_write}, {3'b100, 32'h55, 3'b000});
      end
      @(posedge clk); #1;
    end
    avl_rdv = 1'b0;
    finish_rsp();
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, avl_write, rsp_valid} !== 3'b100) begin
      n_err++; $display("FAIL after_handshake: got %b expected 100", {cmd_ready, avl_write, rsp_valid});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({avl_write, avl_address, avl_wdata} !== {1'b1, 14'h0010, 32'h77}) begin
      n_err++; $display("FAIL next_cmd: wr=%b addr=%h wd=%h expected 1 0010 00000077", avl_write, avl_address, avl_wdata);
    end
    @(posedge clk); #1;
    finish_rsp();
    $display("rsp_hold: held_data=00000055 next_addr=0010");
  endtask

  task automatic test_reset_midflight();
    avl_wr = 1'b0;
    issue_cmd(1'b0, 14'h0030, 4'hF, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, avl_read, avl_write, avl_address, to_count} !== {4'b1000, 14'h0, 16'h0}) begin
      n_err++; $display("FAIL async_reset: ready=%b valid=%b rd=%b wr=%b addr=%h cnt=%0d expected 1 0 0 0 0 0",
                        cmd_ready, rsp_valid, avl_read, avl_write, avl_address, to_count);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    issue_cmd(1'b0, 14'h0031, 4'hF, 32'h0);
    @(posedge clk); #1;
    avl_rdv = 1'b1; avl_rdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    avl_rdv = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_error, rsp_write, rsp_rdata} !== {3'b100, 32'hBEEF}) begin
      n_err++; $display("FAIL post_reset_read: got %h expected %h", {rsp_valid, rsp_error, rsp_write, rsp_rdata}, {3'b100, 32'hBEEF});
    end
    finish_rsp();
    $display("reset_midflight: post-reset data=%h", rsp_rdata);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_read_same_cycle();
    test_timeout();
    test_rsp_hold();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
